// File: rtl/conversor_bcd_secuencial.sv
// Sequential binary-to-BCD converter: samples valor+OFFSET on inicio, runs
// double dabble for WIDTH+1 cycles, and saturates to all-9s when the sum does not fit.
module conversor_bcd_secuencial #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3,
   parameter int OFFSET = 20
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  inicio,
   input  logic [WIDTH-1:0]      valor,
   output logic                  ocupado,
   output logic                  listo,
   output logic                  desborde,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int SUM_W = WIDTH + 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam int SCR_W = BCD_W + SUM_W;
   localparam int CNT_W = $clog2(SUM_W + 1);

   // 10**n clamped to 64 bits, so the overflow limit never wraps for large DIGITS
   function automatic logic [63:0] pot10_sat(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         if (r > 64'd1844674407370955161) r = '1;
         else                             r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] LIMITE = pot10_sat(DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } estado_t;

   estado_t            estado_q,   estado_d;
   logic [SCR_W-1:0]   scratch_q,  scratch_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               ovf_q,      ovf_d;
   logic [BCD_W-1:0]   bcd_q,      bcd_d;
   logic               desborde_q, desborde_d;
   logic               listo_q,    listo_d;
   logic               ocupado_q,  ocupado_d;

   logic [SUM_W-1:0]   suma;
   logic [BCD_W-1:0]   bcd_ajustado;
   logic [SCR_W-1:0]   desplazado;

   assign suma = SUM_W'(valor) + SUM_W'(OFFSET);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_ajuste
         logic [3:0] digito;
         assign digito = scratch_q[SUM_W + 4*gi +: 4];
         assign bcd_ajustado[4*gi +: 4] = (digito >= 4'd5) ? digito + 4'd3 : digito;
      end
   endgenerate

   assign desplazado = {bcd_ajustado[BCD_W-2:0], scratch_q[SUM_W-1:0], 1'b0};

   always_comb begin
      estado_d   = estado_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      desborde_d = desborde_q;
      listo_d    = 1'b0;
      ocupado_d  = ocupado_q;
      case (estado_q)
         IDLE: begin
            ocupado_d = 1'b0;
            if (inicio) begin
               scratch_d = {{BCD_W{1'b0}}, suma};
               cnt_d     = CNT_W'(SUM_W);
               // Overflow is decided on the full-width sum; the scratch may wrap
               ovf_d     = (64'(suma) >= LIMITE);
               ocupado_d = 1'b1;
               estado_d  = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = desplazado;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               estado_d   = DONE;
               ocupado_d  = 1'b0;
               listo_d    = 1'b1;
               desborde_d = ovf_q;
               bcd_d      = ovf_q ? {DIGITS{4'h9}} : desplazado[SCR_W-1 -: BCD_W];
            end
         end
         DONE: begin
            estado_d = IDLE;
         end
         default: begin
            estado_d  = IDLE;
            ocupado_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q   <= IDLE;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         desborde_q <= 1'b0;
         listo_q    <= 1'b0;
         ocupado_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         desborde_q <= desborde_d;
         listo_q    <= listo_d;
         ocupado_q  <= ocupado_d;
      end
   end

   assign ocupado  = ocupado_q;
   assign listo    = listo_q;
   assign desborde = desborde_q;
   assign bcd      = bcd_q;

endmodule

// File: tb/tb_conversor_bcd_secuencial.sv
// Bench for conversor_bcd_secuencial: three configurations side by side, each
// checked against a decimal-arithmetic reference model.
module tb_conversor_bcd_secuencial;

   localparam int W_P   [3] = '{5, 8, 8};
   localparam int D_P   [3] = '{2, 3, 2};
   localparam int OFF_P [3] = '{20, 20, 20};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        inicio_v [3];
   logic [7:0]  valor_v  [3];
   logic        ocup_o   [3];
   logic        listo_o  [3];
   logic        desb_o   [3];
   logic [11:0] bcd_o    [3];

   logic [7:0]  bcd_a, bcd_c;
   logic [11:0] bcd_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   conversor_bcd_secuencial #(.WIDTH(5), .DIGITS(2), .OFFSET(20)) dut_a (
      .clk(clk), .reset_n(reset_n), .inicio(inicio_v[0]), .valor(valor_v[0][4:0]),
      .ocupado(ocup_o[0]), .listo(listo_o[0]), .desborde(desb_o[0]), .bcd(bcd_a));

   conversor_bcd_secuencial #(.WIDTH(8), .DIGITS(3), .OFFSET(20)) dut_b (
      .clk(clk), .reset_n(reset_n), .inicio(inicio_v[1]), .valor(valor_v[1]),
      .ocupado(ocup_o[1]), .listo(listo_o[1]), .desborde(desb_o[1]), .bcd(bcd_b));

   conversor_bcd_secuencial #(.WIDTH(8), .DIGITS(2), .OFFSET(20)) dut_c (
      .clk(clk), .reset_n(reset_n), .inicio(inicio_v[2]), .valor(valor_v[2]),
      .ocupado(ocup_o[2]), .listo(listo_o[2]), .desborde(desb_o[2]), .bcd(bcd_c));

   assign bcd_o[0] = {4'h0, bcd_a};
   assign bcd_o[1] = bcd_b;
   assign bcd_o[2] = {4'h0, bcd_c};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: digits of (v + OFFSET), or all nines when it needs more digits
   task automatic modelo(input int d, input int v, output logic [11:0] b, output logic o);
      int s, lim, t, dig;
      s = v + OFF_P[d];
      lim = 1;
      for (int i = 0; i < D_P[d]; i++) lim = lim * 10;
      o = (s >= lim);
      b = '0;
      t = s;
      for (int i = 0; i < D_P[d]; i++) begin
         dig = o ? 9 : t % 10;
         t = t / 10;
         b = b | (12'(dig) << (4 * i));
      end
   endtask

   task automatic convertir(input int d, input int v, input bit perturbar);
      logic [11:0] eb;
      logic        eo;
      int          c, n_ocup, n_extra;
      modelo(d, v, eb, eo);
      @(negedge clk);
      valor_v[d]  = 8'(v);
      inicio_v[d] = 1'b1;
      @(posedge clk); #1;
      inicio_v[d] = 1'b0;
      valor_v[d]  = 8'($urandom);
      c = 0;
      n_ocup = 0;
      while (!listo_o[d] && c < 40) begin
         if (ocup_o[d]) n_ocup++;
         if (perturbar && c == 2) begin
            inicio_v[d] = 1'b1;
            valor_v[d]  = 8'(v) ^ 8'h15;
         end else begin
            inicio_v[d] = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      inicio_v[d] = 1'b0;
      if (c >= 40) begin
         chk("listo_timeout", 32'(c), 32'(W_P[d] + 1));
      end else begin
         chk("latencia", 32'(c), 32'(W_P[d] + 1));
         chk("ciclos_ocupado", 32'(n_ocup), 32'(W_P[d] + 1));
         chk("ocupado_con_listo", 32'(ocup_o[d]), 32'd0);
         chk("bcd", 32'(bcd_o[d]), 32'(eb));
         chk("desborde", 32'(desb_o[d]), 32'(eo));
         @(posedge clk); #1;
         chk("listo_un_ciclo", 32'(listo_o[d]), 32'd0);
         chk("bcd_retenido", 32'(bcd_o[d]), 32'(eb));
         if (perturbar) begin
            n_extra = 0;
            for (int i = 0; i < W_P[d] + 5; i++) begin
               @(posedge clk); #1;
               if (listo_o[d]) n_extra++;
            end
            chk("listo_extra", 32'(n_extra), 32'd0);
         end
      end
      $display("conv d=%0d valor=%0d -> bcd=%0h desborde=%0b (ref %0h/%0b)",
               d, v, bcd_o[d], desb_o[d], eb, eo);
   endtask

   initial begin
      logic [11:0] eb;
      logic        eo;
      int          pulsos [$];
      int          v;

      for (int d = 0; d < 3; d++) begin
         inicio_v[d] = 1'b0;
         valor_v[d]  = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("reset_bcd", 32'(bcd_o[d]), 32'd0);
         chk("reset_flags", {29'd0, ocup_o[d], listo_o[d], desb_o[d]}, 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;

      // Small configuration: exhaustive sweep of valor
      for (int i = 0; i < 32; i++) convertir(0, i, 1'b0);

      // Default configuration: corners plus random values
      convertir(1, 255, 1'b0);
      convertir(1, 0, 1'b0);
      for (int i = 0; i < 12; i++) convertir(1, int'($urandom_range(0, 255)), 1'b0);

      // Two-digit, 8-bit configuration: around the saturation boundary
      convertir(2, 85, 1'b0);
      convertir(2, 79, 1'b0);
      convertir(2, 80, 1'b0);
      for (int i = 0; i < 10; i++) convertir(2, int'($urandom_range(0, 255)), 1'b0);

      // Extra inicio during SHIFT must be ignored
      convertir(1, int'($urandom_range(0, 255)), 1'b1);
      convertir(0, int'($urandom_range(0, 31)), 1'b1);

      // inicio held high: one result every SUM_W+2 cycles
      v = int'($urandom_range(0, 255));
      modelo(1, v, eb, eo);
      @(negedge clk);
      valor_v[1]  = 8'(v);
      inicio_v[1] = 1'b1;
      for (int c = 0; c < 3 * 11 + 2; c++) begin
         @(posedge clk); #1;
         if (listo_o[1]) begin
            pulsos.push_back(c);
            chk("continuo_bcd", 32'(bcd_o[1]), 32'(eb));
         end
      end
      inicio_v[1] = 1'b0;
      chk("continuo_pulsos", 32'(pulsos.size()), 32'd3);
      if (pulsos.size() >= 2) chk("continuo_periodo", 32'(pulsos[1] - pulsos[0]), 32'd11);
      if (pulsos.size() >= 3) chk("continuo_periodo2", 32'(pulsos[2] - pulsos[1]), 32'd11);
      repeat (14) @(posedge clk);
      $display("continuo valor=%0d pulsos=%0d", v, pulsos.size());

      // Asynchronous reset in the middle of SHIFT aborts the conversion
      @(negedge clk);
      valor_v[1]  = 8'd200;
      inicio_v[1] = 1'b1;
      @(posedge clk); #1;
      inicio_v[1] = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_ocupado", 32'(ocup_o[1]), 32'd0);
      chk("abort_listo", 32'(listo_o[1]), 32'd0);
      chk("abort_bcd", 32'(bcd_o[1]), 32'd0);
      chk("abort_desborde", 32'(desb_o[1]), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      v = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (listo_o[1]) v++;
      end
      chk("abort_sin_listo", 32'(v), 32'd0);
      chk("abort_bcd_cero", 32'(bcd_o[1]), 32'd0);
      $display("reset mid-SHIFT done");
      convertir(1, int'($urandom_range(0, 255)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
